uart_io_rx: RTL and testbench

UART_IO_RX -- requirements
Module: uart_io_rx

---
 rtl/uart_io_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_io_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_rx.sv
// uart_io_rx: 8N1 UART receiver feeding a newline-terminated 4-byte frame assembler.
// Latency: rx_valid 1 cycle after the mid-stop-bit sample; frame_valid/frame_err 1 cycle after the 0x0A byte.
// Backpressure: none; strobes are single-cycle and must be consumed when they occur.
// Optional macro UART_IO_RX_TIMEOUT_EN adds an inter-byte abort for stalled partial frames.
module uart_io_rx #(
   parameter int CLK_FRE      = 25,
   parameter int UART_RATE    = 115200,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic [31:0] io_data,
   output logic        frame_valid,
   output logic        frame_err
);

   localparam int BIT_CYC = CLK_FRE * 1000000 / UART_RATE;
   localparam int HALF    = BIT_CYC / 2;
   localparam int TW      = $clog2(BIT_CYC + 1);
   localparam logic [TW-1:0] T_FULL = TW'(BIT_CYC - 1);
   localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic          sync1, rx_s;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          timer_clr, bit_smp, byte_ok, byte_bad;

   logic [31:0]   shift;
   logic [2:0]    cnt;
   logic          bad;
   logic          asm_busy;
   logic          to_hit;

   // Two-flop synchronizer; resets to the idle-high line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= uart_rx;
         rx_s  <= sync1;
      end
   end

   // Bit FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Bit FSM next state and sampling controls.
   always_comb begin
      state_nxt = state;
      timer_clr = 1'b0;
      bit_smp   = 1'b0;
      byte_ok   = 1'b0;
      byte_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               timer_clr = 1'b1;
            end
         end
         START: begin
            if (timer == T_HALF) begin
               timer_clr = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == T_FULL) begin
               timer_clr = 1'b1;
               bit_smp   = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (timer == T_FULL) begin
               timer_clr = 1'b1;
               if (rx_s) begin
                  byte_ok   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  byte_bad  = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bit timer, bit index, data shifter and byte output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer    <= '0;
         bit_idx  <= 3'd0;
         shreg    <= 8'd0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= byte_ok;
         if (state == IDLE || state == BREAK || timer_clr) timer <= '0;
         else                                              timer <= timer + 1'b1;
         if (state == START) bit_idx <= 3'd0;
         else if (bit_smp) begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {rx_s, shreg[7:1]};
         end
         if (byte_ok) rx_data <= shreg;
      end
   end

   assign asm_busy = (cnt != 3'd0) || bad;

`ifdef UART_IO_RX_TIMEOUT_EN
   localparam int TO_CYC = TIMEOUT_BITS * BIT_CYC;
   localparam int OW     = $clog2(TO_CYC + 1);
   logic [OW-1:0] to_cnt;

   // A new byte always wins over an expiring window.
   assign to_hit = asm_busy && !rx_valid && (to_cnt == OW'(TO_CYC - 1));

   // Inter-byte window counter; idle while the assembler is empty.
   always_ff @(posedge clk) begin
      if (rst || rx_valid || !asm_busy || to_hit) to_cnt <= '0;
      else                                        to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   // Frame assembler: first byte lands in io_data[31:24]; 0x0A closes the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift       <= 32'd0;
         cnt         <= 3'd0;
         bad         <= 1'b0;
         io_data     <= 32'd0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (rx_valid) begin
            if (rx_data == 8'h0A) begin
               if (cnt == 3'd4 && !bad) begin
                  io_data     <= shift;
                  frame_valid <= 1'b1;
               end else begin
                  frame_err   <= 1'b1;
               end
               shift <= 32'd0;
               cnt   <= 3'd0;
               bad   <= 1'b0;
            end else begin
               shift <= {shift[23:0], rx_data};
               if (cnt != 3'd5) cnt <= cnt + 3'd1;
            end
         end else if (to_hit) begin
            frame_err <= 1'b1;
            shift     <= 32'd0;
            cnt       <= 3'd0;
            bad       <= 1'b0;
         end
         // A framing error marks the frame currently being assembled.
         if (byte_bad) bad <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_io_rx.sv
// tb_uart_io_rx: directed vector bench for uart_io_rx at 25 MHz / 115200 baud.
// Table of frames with expected strobe counts, bytes and payload, plus hand sequences.
// Covers glitch rejection, mid-byte reset, and partial-frame timeout/persistence.
module tb_uart_io_rx;

   localparam int BIT_CYC = 217;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rx = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [31:0] io_data;
   logic        frame_valid;
   logic        frame_err;

   uart_io_rx dut (
      .clk         (clk),
      .rst         (rst),
      .uart_rx     (uart_rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .io_data     (io_data),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   always #20 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor state (written only by the monitor process)
   int         n_rxv = 0, n_fv = 0, n_fe = 0, n_brk = 0, n_viol = 0;
   logic [7:0] rxq[$];
   logic       p_rxv = 1'b0, p_fv = 1'b0, p_fe = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) begin
         n_rxv++;
         rxq.push_back(rx_data);
      end
      if (frame_valid) n_fv++;
      if (frame_err)   n_fe++;
      if (dut.state == 3'd4) n_brk++;
      if ((rx_valid && p_rxv) || (frame_valid && p_fv) || (frame_err && p_fe) ||
          (frame_valid && frame_err)) n_viol++;
      p_rxv = rx_valid;
      p_fv  = frame_valid;
      p_fe  = frame_err;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      uart_rx = bad_stop ? 1'b0 : 1'b1;
      repeat (BIT_CYC) @(negedge clk);
      if (bad_stop) begin
         uart_rx = 1'b1;
         repeat (BIT_CYC) @(negedge clk);
      end
      repeat (8) @(negedge clk);
   endtask

   typedef struct {
      logic [63:0] chars;    // first char in bits [63:56]
      int          n;
      int          bad_idx;  // char sent with a low stop bit, -1 for none
      int          exp_rxv;
      int          exp_fv;
      int          exp_fe;
      logic [31:0] exp_io;
      bit          exp_brk;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int b_rxv, b_fv, b_fe, b_brk, base, j;
      logic [7:0] c, got;

      vecs[0] = '{64'h41424344_0A000000, 5, -1, 5, 1, 0, 32'h41424344, 1'b0}; // "ABCD\n"
      vecs[1] = '{64'h41420A00_00000000, 3, -1, 3, 0, 1, 32'h41424344, 1'b0}; // "AB\n"
      vecs[2] = '{64'h5758595A_0A000000, 5, -1, 5, 1, 0, 32'h5758595A, 1'b0}; // "WXYZ\n"
      vecs[3] = '{64'h41424344_450A0000, 6, -1, 6, 0, 1, 32'h5758595A, 1'b0}; // "ABCDE\n"
      vecs[4] = '{64'h0A000000_00000000, 1, -1, 1, 0, 1, 32'h5758595A, 1'b0}; // "\n"
      vecs[5] = '{64'h41424344_0A000000, 5,  2, 4, 0, 1, 32'h5758595A, 1'b1}; // "ABCD\n", bad stop on 'C'

      // Reset state
      repeat (5) @(negedge clk);
      check("reset rx_data", {24'd0, rx_data}, 32'd0);
      check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset io_data", io_data, 32'd0);
      check("reset frame_valid", {31'd0, frame_valid}, 32'd0);
      check("reset frame_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         b_rxv = n_rxv; b_fv = n_fv; b_fe = n_fe; b_brk = n_brk; base = rxq.size();
         for (int i = 0; i < vecs[v].n; i++) begin
            c = vecs[v].chars[63 - 8*i -: 8];
            send_byte(c, (i == vecs[v].bad_idx));
         end
         repeat (20) @(negedge clk);
         check($sformatf("vec%0d rx_valid count", v), n_rxv - b_rxv, vecs[v].exp_rxv);
         check($sformatf("vec%0d frame_valid count", v), n_fv - b_fv, vecs[v].exp_fv);
         check($sformatf("vec%0d frame_err count", v), n_fe - b_fe, vecs[v].exp_fe);
         check($sformatf("vec%0d io_data", v), io_data, vecs[v].exp_io);
         check($sformatf("vec%0d break seen", v), {31'd0, (n_brk > b_brk)}, {31'd0, vecs[v].exp_brk});
         j = 0;
         for (int i = 0; i < vecs[v].n; i++) begin
            if (i != vecs[v].bad_idx) begin
               c   = vecs[v].chars[63 - 8*i -: 8];
               got = (base + j < rxq.size()) ? rxq[base + j] : 8'hxx;
               check($sformatf("vec%0d byte%0d", v, i), {24'd0, got}, {24'd0, c});
               j++;
            end
         end
      end

      // 50-cycle low glitch on an idle line
      b_rxv = n_rxv; b_fe = n_fe;
      uart_rx = 1'b0;
      repeat (50) @(negedge clk);
      uart_rx = 1'b1;
      repeat (400) @(negedge clk);
      check("glitch rx_valid count", n_rxv - b_rxv, 0);
      check("glitch frame_err count", n_fe - b_fe, 0);

      // Reset during bit 3 of 'B' after a complete 'A'
      b_rxv = n_rxv;
      send_byte(8'h41, 1'b0);
      check("pre-reset 'A' received", n_rxv - b_rxv, 1);
      uart_rx = 1'b0;                                     // start bit of 'B' (0x42)
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         uart_rx = (i == 1);
         repeat (BIT_CYC) @(negedge clk);
      end
      uart_rx = 1'b0;                                     // bit 3
      repeat (100) @(negedge clk);
      rst = 1'b1;
      b_rxv = n_rxv; b_fv = n_fv; b_fe = n_fe;
      repeat (BIT_CYC - 100) @(negedge clk);
      for (int i = 4; i < 8; i++) begin
         uart_rx = (i == 6);
         repeat (BIT_CYC) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("mid-byte reset rx_valid", n_rxv - b_rxv, 0);
      check("mid-byte reset frame_valid", n_fv - b_fv, 0);
      check("mid-byte reset frame_err", n_fe - b_fe, 0);
      check("mid-byte reset io_data", io_data, 32'd0);
      check("mid-byte reset rx_data", {24'd0, rx_data}, 32'd0);

      b_fv = n_fv; b_fe = n_fe;
      send_byte(8'h31, 1'b0); send_byte(8'h32, 1'b0); send_byte(8'h33, 1'b0);
      send_byte(8'h34, 1'b0); send_byte(8'h0A, 1'b0);
      repeat (20) @(negedge clk);
      check("post-reset frame_valid", n_fv - b_fv, 1);
      check("post-reset frame_err", n_fe - b_fe, 0);
      check("post-reset io_data", io_data, 32'h31323334);

      // Stalled partial frame
      b_fv = n_fv; b_fe = n_fe;
      send_byte(8'h41, 1'b0); send_byte(8'h42, 1'b0);
`ifdef UART_IO_RX_TIMEOUT_EN
      repeat (4500) @(negedge clk);
      check("timeout frame_err", n_fe - b_fe, 1);
      check("timeout frame_valid", n_fv - b_fv, 0);
      b_fv = n_fv; b_fe = n_fe;
      send_byte(8'h41, 1'b0); send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b0);
      send_byte(8'h44, 1'b0); send_byte(8'h0A, 1'b0);
      repeat (20) @(negedge clk);
      check("after timeout frame_valid", n_fv - b_fv, 1);
      check("after timeout frame_err", n_fe - b_fe, 0);
      check("after timeout io_data", io_data, 32'h41424344);
`else
      repeat (5000) @(negedge clk);
      check("no timeout frame_err", n_fe - b_fe, 0);
      send_byte(8'h43, 1'b0); send_byte(8'h44, 1'b0); send_byte(8'h0A, 1'b0);
      repeat (20) @(negedge clk);
      check("persisted frame_valid", n_fv - b_fv, 1);
      check("persisted frame_err", n_fe - b_fe, 0);
      check("persisted io_data", io_data, 32'h41424344);
`endif

      check("strobe width/exclusivity violations", n_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
